// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and widths for the MEM pipeline stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int DATA_W          = 32;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    result;
        logic [DATA_W-1:0]    read_data;
    } mw_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ============================================================================
// Module : mem_access_stage_if
// Brief  : Data-memory request/acknowledge bus between MEM stage and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if;
    import cpu_pkg::*;

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

`default_nettype wire

// File: rtl/mem_access_stage_mw_pipe_reg.sv
// ============================================================================
// Module : mw_pipe_reg
// Brief  : MEM/WB pipeline register with load, bubble insert and async reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mw_pipe_reg
    import cpu_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load,
    input  wire logic bubble,
    input  wire mw_t  d,
    output mw_t       q
);

    mw_t w_entry;

    // A write-back with no valid instruction or to x0 never writes the file.
    always_comb begin
        w_entry           = d;
        w_entry.reg_write = d.reg_write & d.valid & (d.rd != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            if (bubble) begin
                q.valid     <= 1'b0;
                q.reg_write <= 1'b0;
            end else begin
                q <= w_entry;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module : mem_access_stage
// Brief  : MEM pipeline stage: data-memory handshake, stall, branch resolve.
//          Optional access timeout enabled by MEM_ACCESS_STAGE_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 em_valid,
    input  wire logic                 em_mem_read,
    input  wire logic                 em_mem_write,
    input  wire logic                 em_mem_to_reg,
    input  wire logic                 em_reg_write,
    input  wire logic                 em_branch,
    input  wire logic                 em_zero,
    input  wire logic [REG_IDX_W-1:0] em_rd,
    input  wire logic [DATA_W-1:0]    em_result,
    input  wire logic [DATA_W-1:0]    em_wdata,
    mem_access_stage_if.master        dmem,
    output logic                      mem_stall,
    output logic                      pc_src,
    output logic                      mw_valid,
    output logic                      mw_reg_write,
    output logic                      mw_mem_to_reg,
    output logic [REG_IDX_W-1:0]      mw_rd,
    output logic [DATA_W-1:0]         mw_result,
    output logic [DATA_W-1:0]         mw_read_data,
    output logic                      err
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e        r_state;
    mem_state_e        w_state_next;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_memop;
    logic              w_ack_in_wait;
    logic              w_timeout;
    logic              w_done;
    mw_t               w_mw_d;
    mw_t               w_mw_q;

    assign w_memop       = em_valid & (em_mem_read | em_mem_write);
    assign w_ack_in_wait = (r_state == ST_WAIT) & dmem.ack;
    assign w_done        = w_ack_in_wait | w_timeout;

`ifdef MEM_ACCESS_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    // Ack on the final counted cycle still completes the access normally.
    assign w_timeout = (r_state == ST_WAIT) & ~dmem.ack
                     & (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == ST_WAIT && !w_done) ? r_wait_cnt + 1'b1 : '0;
            r_err      <= r_err | w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign mem_stall = w_memop & ~w_done;
    assign pc_src    = em_valid & em_branch & em_zero & ~mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_memop) w_state_next = ST_WAIT;
            ST_WAIT: if (w_done)  w_state_next = ST_IDLE;
            default:              w_state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured once on entry so they stay stable in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_IDLE && w_memop) begin
            r_we    <= em_mem_write;
            r_addr  <= em_result;
            r_wdata <= em_wdata;
        end
    end

    assign dmem.req   = (r_state == ST_WAIT);
    assign dmem.we    = r_we;
    assign dmem.addr  = r_addr;
    assign dmem.wdata = r_wdata;

    always_comb begin
        w_mw_d            = '0;
        w_mw_d.valid      = em_valid;
        w_mw_d.reg_write  = em_reg_write & ~w_timeout;
        w_mw_d.mem_to_reg = em_mem_to_reg;
        w_mw_d.rd         = em_rd;
        w_mw_d.result     = em_result;
        w_mw_d.read_data  = (w_ack_in_wait && !r_we) ? dmem.rdata : '0;
    end

    mw_pipe_reg u_mw_pipe_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (1'b1),
        .bubble (mem_stall),
        .d      (w_mw_d),
        .q      (w_mw_q)
    );

    assign mw_valid      = w_mw_q.valid;
    assign mw_reg_write  = w_mw_q.reg_write;
    assign mw_mem_to_reg = w_mw_q.mem_to_reg;
    assign mw_rd         = w_mw_q.rd;
    assign mw_result     = w_mw_q.result;
    assign mw_read_data  = w_mw_q.read_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Self-checking bench for mem_access_stage against a transaction model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
    import cpu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        em_valid, em_mem_read, em_mem_write, em_mem_to_reg;
    logic        em_reg_write, em_branch, em_zero;
    logic [4:0]  em_rd;
    logic [31:0] em_result, em_wdata;
    logic        mem_stall, pc_src, mw_valid, mw_reg_write, mw_mem_to_reg, err;
    logic [4:0]  mw_rd;
    logic [31:0] mw_result, mw_read_data;

    int pass_cnt = 0;
    int total    = 0;

    mem_access_stage_if dif();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .em_valid(em_valid), .em_mem_read(em_mem_read), .em_mem_write(em_mem_write),
        .em_mem_to_reg(em_mem_to_reg), .em_reg_write(em_reg_write),
        .em_branch(em_branch), .em_zero(em_zero), .em_rd(em_rd),
        .em_result(em_result), .em_wdata(em_wdata),
        .dmem(dif.master),
        .mem_stall(mem_stall), .pc_src(pc_src),
        .mw_valid(mw_valid), .mw_reg_write(mw_reg_write), .mw_mem_to_reg(mw_mem_to_reg),
        .mw_rd(mw_rd), .mw_result(mw_result), .mw_read_data(mw_read_data),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic em_clear();
        em_valid = 0; em_mem_read = 0; em_mem_write = 0; em_mem_to_reg = 0;
        em_reg_write = 0; em_branch = 0; em_zero = 0; em_rd = 0;
        em_result = 0; em_wdata = 0;
    endtask

    // Expected write-back view of one retired instruction.
    task automatic chk_wb(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                          input logic [31:0] res, input logic [31:0] rdat);
        chk({tag, ".mw_valid"},     mw_valid,     v);
        chk({tag, ".mw_reg_write"}, mw_reg_write, rw && v && (rd != 0));
        chk({tag, ".mw_rd"},        mw_rd,        rd);
        chk({tag, ".mw_result"},    mw_result,    res);
        chk({tag, ".mw_read_data"}, mw_read_data, rdat);
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic do_nonmem(input string tag, input logic v, input logic rw, input logic br,
                             input logic z, input logic [4:0] rd, input logic [31:0] res);
        em_clear();
        em_valid = v; em_reg_write = rw; em_branch = br; em_zero = z;
        em_rd = rd; em_result = res; em_wdata = $urandom;
        dif.ack = 1'($urandom_range(0, 1));
        dif.rdata = $urandom;
        #1;
        chk({tag, ".stall"},  mem_stall, 1'b0);
        chk({tag, ".pc_src"}, pc_src,    v && br && z);
        @(negedge clk);
        chk_wb(tag, v, rw, rd, res, 32'h0);
    endtask

    // Memory op whose ack arrives in WAIT cycle k (0-based).
    task automatic do_memop(input string tag, input logic is_wr, input logic rw,
                            input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] wdat, input int k, input logic [31:0] rdat);
        int stalls;
        stalls = 0;
        em_clear();
        em_valid = 1; em_mem_read = !is_wr; em_mem_write = is_wr;
        em_mem_to_reg = !is_wr; em_reg_write = rw; em_rd = rd;
        em_result = addr; em_wdata = wdat;
        dif.ack = 1'($urandom_range(0, 1));
        dif.rdata = $urandom;
        #1;
        if (mem_stall) stalls++;
        chk({tag, ".req_idle"}, dif.req, 1'b0);
        for (int j = 0; j <= k; j++) begin
            @(negedge clk);
            dif.ack   = (j == k);
            dif.rdata = (j == k) ? rdat : $urandom;
            #1;
            if (mem_stall) stalls++;
            chk({tag, ".req"},   dif.req,   1'b1);
            chk({tag, ".we"},    dif.we,    is_wr);
            chk({tag, ".addr"},  dif.addr,  addr);
            chk({tag, ".wdata"}, dif.wdata, wdat);
            chk({tag, ".bubble_valid"}, mw_valid,     1'b0);
            chk({tag, ".bubble_rw"},    mw_reg_write, 1'b0);
        end
        @(negedge clk);
        dif.ack = 0;
        chk({tag, ".stall_cycles"}, stalls, k + 1);
        chk({tag, ".req_done"}, dif.req, 1'b0);
        chk_wb(tag, 1'b1, rw, rd, addr, is_wr ? 32'h0 : rdat);
    endtask

    initial begin
        rst = 0;
        em_clear();
        dif.ack = 0; dif.rdata = 0;
        #1;
        chk("rst.req",   dif.req,   1'b0);
        chk("rst.we",    dif.we,    1'b0);
        chk("rst.addr",  dif.addr,  32'h0);
        chk("rst.wdata", dif.wdata, 32'h0);
        chk("rst.err",   err,       1'b0);
        chk("rst.mw_mem_to_reg", mw_mem_to_reg, 1'b0);
        chk_wb("rst", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1;

        do_memop("lw", 1'b0, 1'b1, 5'd3, 32'h40, 32'h0, 0, 32'h1234_5678);
        chk("lw.mem_to_reg", mw_mem_to_reg, 1'b1);
        do_memop("sw", 1'b1, 1'b0, 5'd0, 32'h80, 32'hA5A5_A5A5, 3, 32'hDEAD_BEEF);

        do_nonmem("add_x0", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0055);
        do_nonmem("beq",    1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0000_0100);
        do_nonmem("after_beq", 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0033);

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_memop("rnd_mem", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         5'($urandom), $urandom, $urandom, int'($urandom_range(0, 5)), $urandom);
            else
                do_nonmem("rnd_alu", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom), $urandom);
        end

        // Reset in the middle of an access, then a stray ack afterwards.
        em_clear();
        em_valid = 1; em_mem_read = 1; em_rd = 5'd4; em_result = 32'h200;
        @(negedge clk);
        #1;
        chk("rstw.req_before", dif.req, 1'b1);
        #1 rst = 0;
        #1;
        chk("rstw.req_async", dif.req, 1'b0);
        chk_wb("rstw.async", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        em_clear();
        @(negedge clk);
        rst = 1;
        dif.ack = 1; dif.rdata = 32'hCAFE_F00D;
        #1;
        chk("rstw.stall_idle", mem_stall, 1'b0);
        @(negedge clk);
        dif.ack = 0;
        chk("rstw.req_after", dif.req, 1'b0);
        chk_wb("rstw.after", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        do_memop("post_rst", 1'b0, 1'b1, 5'd8, 32'h44, 32'h0, 1, 32'h0BAD_CAFE);

`ifdef MEM_ACCESS_STAGE_TIMEOUT_EN
        em_clear();
        em_valid = 1; em_mem_read = 1; em_mem_to_reg = 1; em_reg_write = 1;
        em_rd = 5'd7; em_result = 32'h300;
        #1;
        chk("to.stall_idle", mem_stall, 1'b1);
        for (int j = 0; j < TO; j++) begin
            @(negedge clk);
            dif.ack = 0; dif.rdata = $urandom;
            #1;
            chk("to.req",   dif.req,   1'b1);
            chk("to.stall", mem_stall, (j != TO - 1));
            chk("to.err_early", err, 1'b0);
        end
        @(negedge clk);
        chk("to.req_drop", dif.req, 1'b0);
        chk("to.err", err, 1'b1);
        chk_wb("to", 1'b1, 1'b0, 5'd7, 32'h300, 32'h0);
        do_nonmem("to_next", 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h11);
        chk("to.err_sticky", err, 1'b1);
        #1 rst = 0;
        #1;
        chk("to.err_reset", err, 1'b0);
        @(negedge clk);
        rst = 1;
`else
        em_clear();
        em_valid = 1; em_mem_read = 1; em_reg_write = 1; em_rd = 5'd7; em_result = 32'h300;
        #1;
        chk("hold.stall_idle", mem_stall, 1'b1);
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            dif.ack = 0; dif.rdata = $urandom;
            #1;
            chk("hold.stall", mem_stall, 1'b1);
            chk("hold.req",   dif.req,   1'b1);
            chk("hold.err",   err,       1'b0);
        end
        @(negedge clk);
        dif.ack = 1; dif.rdata = 32'h7777_0001;
        #1;
        chk("hold.stall_ack", mem_stall, 1'b0);
        @(negedge clk);
        dif.ack = 0;
        chk_wb("hold", 1'b1, 1'b1, 5'd7, 32'h300, 32'h7777_0001);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
